// File: rtl/ones_counter_arbiter.sv
// Round-robin arbiter/sequencer sharing one ones-counter among NUM_REQ requesters.
// Optional watchdog on the counter's done: define ONES_ARB_TIMEOUT_EN (adds timeout_err).
module ones_counter_arbiter #(
    parameter int N       = 8,
    parameter int NUM_REQ = 4,
    parameter int RES_W   = $clog2(N + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*N-1:0]   data_in,
    output logic [NUM_REQ-1:0]     grant,
    output logic [RES_W-1:0]       result_out,
    output logic                   result_valid,
    output logic                   busy,
    output logic                   cnt_s,
    output logic [N-1:0]           cnt_A,
    input  logic                   cnt_done,
    input  logic [RES_W-1:0]       cnt_result
`ifdef ONES_ARB_TIMEOUT_EN
    ,
    output logic                   timeout_err
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE,
        S_RELEASE
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   ptr, owner, win_idx, ptr_nxt;
    logic               win_any;
    logic [NUM_REQ-1:0] owner_oh;
    logic               wd_expired;
    logic               release_hold;

    // First set request at or above the pointer, wrapping around.
    always_comb begin
        int idx;
        win_any = 1'b0;
        win_idx = '0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!win_any && req[idx]) begin
                win_any = 1'b1;
                win_idx = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        owner_oh = '0;
        for (int i = 0; i < NUM_REQ; i++)
            owner_oh[i] = (owner == IDX_W'(i));
    end

    assign ptr_nxt = (int'(owner) == NUM_REQ - 1) ? '0 : owner + 1'b1;

`ifdef ONES_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(N + 5);
    logic [WD_W-1:0] wd;

    // wd is 0 in the first RUN cycle, so expiry lands on the (N+4)th RUN cycle.
    assign wd_expired   = (state == S_RUN) && !cnt_done && (wd == WD_W'(N + 3));
    assign release_hold = timeout_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            wd          <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= wd_expired;
            if (state == S_LOAD)
                wd <= '0;
            else if (state == S_RUN && !wd_expired)
                wd <= wd + 1'b1;
        end
    end
`else
    assign wd_expired   = 1'b0;
    assign release_hold = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (win_any) state_nxt = S_LOAD;
            S_LOAD:    state_nxt = S_RUN;
            S_RUN: begin
                if (cnt_done)        state_nxt = S_DONE;
                else if (wd_expired) state_nxt = S_RELEASE;
            end
            S_DONE:    state_nxt = S_RELEASE;
            S_RELEASE: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        grant        = '0;
        cnt_s        = 1'b0;
        result_valid = 1'b0;
        busy         = (state != S_IDLE);
        case (state)
            S_LOAD: grant = owner_oh;
            S_RUN: begin
                grant = owner_oh;
                cnt_s = 1'b1;
            end
            S_DONE: begin
                grant        = owner_oh;
                cnt_s        = 1'b1;
                result_valid = 1'b1;
            end
            // Grant is held through the timeout pulse so the owner can attribute it.
            S_RELEASE: if (release_hold) grant = owner_oh;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            ptr        <= '0;
            owner      <= '0;
            cnt_A      <= '0;
            result_out <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && win_any) begin
                owner <= win_idx;
                cnt_A <= data_in[int'(win_idx)*N +: N];
            end
            if (state == S_RUN && cnt_done)
                result_out <= cnt_result;
            if (state == S_DONE || wd_expired)
                ptr <= ptr_nxt;
        end
    end

endmodule

// File: doc/ones_counter_arbiter.md
Name: ones_counter_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one ones-counter unit (controller plus datapath) among NUM_REQ requesters.
- Latches the winning requester's word and drives the counter's start/load handshake.
- Waits for the counter's done, captures the bit count, returns it to the winner, then releases the counter for the next grant.
- Sits between client logic and a single ones-counter instance; both are clocked by the same clk and reset.

Parameters:
- N, 8, data word width; must match the counter's N.
- NUM_REQ, 4, number of requesters, 2..8.
- RES_W, $clog2(N+1), width of a bit-count result.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req  input  NUM_REQ  level request, one bit per requester
- data_in  input  NUM_REQ*N  requester words; requester i uses bits [i*N +: N]
- grant  output  NUM_REQ  one-hot; identifies the requester owning the current transaction
- result_out  output  RES_W  captured count; valid only while result_valid is high
- result_valid  output  1  one-cycle pulse; coincides with grant of the owner
- busy  output  1  high in every state except IDLE
- cnt_s  output  1  start input of the counter
- cnt_A  output  N  word presented to the counter; registered, stable for the whole transaction
- cnt_done  input  1  done output of the counter
- cnt_result  input  RES_W  count output of the counter

Behaviour:
- Reset (synchronous, active-high), also mid-transaction, takes effect at the next posedge:
  - state IDLE, round-robin pointer 0, all outputs 0, cnt_A register 0.
  - Any in-flight transaction is dropped with no result_valid.
  - The counter shares reset, so it also returns to its idle state.
- IDLE:
  - cnt_s=0, grant=0.
  - If any req bit is set, pick the first set bit searching from pointer upward with wraparound.
  - Latch data_in of the winner into cnt_A and its index into owner; go to LOAD.
  - No req set: stay in IDLE.
- LOAD:
  - cnt_s=0, grant[owner]=1.
  - Exactly one cycle, during which the counter samples cnt_A; go to RUN.
- RUN:
  - cnt_s=1, grant[owner]=1.
  - Stay until cnt_done=1, then go to DONE.
  - req changes during RUN are ignored; the transaction completes even if req[owner] falls.
- DONE:
  - cnt_s=1, grant[owner]=1, result_valid=1, result_out = cnt_result sampled in this cycle (held in a register).
  - Pointer <= owner+1 mod NUM_REQ; go to RELEASE.
- RELEASE:
  - cnt_s=0, grant=0; exactly one cycle so the counter leaves done and returns to its idle state; go to IDLE.
- Latency:
  - req to grant: 1 cycle.
  - grant to result_valid: 2 + (counter cycles to done); worst case for word all-ones with MSB set is N+2 counter cycles.
  - Back-to-back grants are separated by at least 2 cycles (RELEASE, IDLE).
- A requester still holding req after its result competes again at lowest priority.
- Simultaneous requests resolve by round-robin only; no requester waits more than NUM_REQ-1 other transactions.
- cnt_A == 0: the counter finishes immediately and result_out = 0.
- Result width: the count of an N-bit word is 0..N and always fits in RES_W.
- cnt_done seen outside RUN is ignored.

Optional Feature:
- Macro: ONES_ARB_TIMEOUT_EN.
- When defined:
  - Adds output timeout_err (1 bit) and an internal watchdog counter, cleared on entry to RUN.
  - If cnt_done is not seen within N+4 cycles of RUN, go to RELEASE and pulse timeout_err=1 for one cycle; grant[owner] stays high during that pulse cycle.
  - No result_valid is issued; the pointer advances as in DONE.
  - timeout_err resets to 0.
- When undefined:
  - No timeout_err port and no watchdog; RUN waits on cnt_done indefinitely.

Test Plan:
- Single request: req=4'b0001, data_in[0]=8'hB5 -> grant=0001 one cycle later; result_valid pulse with result_out=5; busy=0 two cycles after the pulse.
- Round-robin: req=4'b1111 held, words 8'h00, 8'hFF, 8'h0F, 8'h80 -> grants in order 0,1,2,3,0; results 0, 8, 4, 1; pointer wraps to 0.
- Simultaneous requests after pointer=2: req=4'b0011 -> requester 0 served before 1; req=4'b1010 -> requester 3 served before 1.
- Data stability: requester 0 changes data_in[0] from 8'h03 to 8'hFF during RUN -> cnt_A held at 8'h03, result_out=2.
- Reset mid-RUN: assert reset for one cycle during RUN -> next cycle busy=0, cnt_s=0, grant=0, no result_valid; a new req=4'b0100 is granted to requester 2.
- With ONES_ARB_TIMEOUT_EN: counter model with cnt_done tied 0 -> timeout_err pulses exactly N+4 cycles after RUN entry, no result_valid, next requester granted.
